// File: rtl/d_split_ctrl.sv
// rtl/d_split_ctrl.sv - even/odd dcache split-access sequencer
// Runs one load/store at a time through lookup, miss/wake replay and merge capture.
module d_split_ctrl #(
    parameter int OOO_TAG_SIZE = 10,
    parameter int MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_sext,
    input  logic [2:0]              req_op,
    input  logic [OOO_TAG_SIZE-1:0] req_tag,
    output logic                    lk_e_valid,
    output logic [31:0]             lk_e_addr,
    output logic                    lk_o_valid,
    output logic [31:0]             lk_o_addr,
    input  logic                    hit_e,
    input  logic                    hit_o,
    output logic                    miss_e,
    output logic                    miss_o,
    input  logic                    wake_e,
    input  logic                    wake_o,
    output logic                    use_e_as_0,
    output logic                    need_p1,
    output logic [1:0]              mrg_size,
    output logic                    mrg_sext,
    input  logic [31:0]             mrg_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic [OOO_TAG_SIZE-1:0] resp_tag,
    output logic                    resp_err
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [2:0] OP_LD = 3'd1;
    localparam logic [2:0] OP_ST = 3'd2;

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q;
    logic [1:0]              size_q;
    logic                    sext_q;
    logic [2:0]              op_q;
    logic [OOO_TAG_SIZE-1:0] tag_q;
    logic [RW-1:0]           retry_q;
    logic                    pend_e_q, pend_o_q;
    logic [31:0]             resp_data_q;
    logic                    resp_err_q;

    logic [31:0] line0, line1;
    logic [4:0]  bytes5;
    logic        use_e, p1, need_e, need_o, busy;
    logic        all_hit, retry_max, req_illegal;
    logic        pend_e_nx, pend_o_nx;

    assign line0 = {addr_q[31:4], 4'b0000};
    assign line1 = line0 + 32'd16;
    assign use_e = ~addr_q[4];

    always_comb begin
        bytes5 = 5'd4;
        case (size_q)
            2'd0:    bytes5 = 5'd1;
            2'd1:    bytes5 = 5'd2;
            default: bytes5 = 5'd4;
        endcase
    end

    assign p1 = ({1'b0, addr_q[3:0]} + bytes5) > 5'd16;

    // Bank 0 holds line0; the other bank is only touched when the access crosses lines.
    assign need_e = use_e | p1;
    assign need_o = ~use_e | p1;

    assign busy        = (state_q != IDLE);
    assign all_hit     = (~need_e | hit_e) & (~need_o | hit_o);
    assign retry_max   = (retry_q == RW'(MAX_RETRY));
    assign req_illegal = ((req_op != OP_LD) && (req_op != OP_ST)) || (req_size == 2'd2);
    assign pend_e_nx   = pend_e_q & ~wake_e;
    assign pend_o_nx   = pend_o_q & ~wake_o;

    assign lk_e_addr  = busy ? (use_e ? line0 : line1) : 32'd0;
    assign lk_o_addr  = busy ? (use_e ? line1 : line0) : 32'd0;
    assign use_e_as_0 = busy & use_e;
    assign need_p1    = busy & p1;
    assign mrg_size   = busy ? size_q : 2'd0;
    assign mrg_sext   = busy & sext_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign resp_tag   = tag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        lk_e_valid = 1'b0;
        lk_o_valid = 1'b0;
        miss_e     = 1'b0;
        miss_o     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_illegal ? RESP : LOOKUP;
            end
            LOOKUP: begin
                lk_e_valid = need_e;
                lk_o_valid = need_o;
                state_d    = CHECK;
            end
            CHECK: begin
                if (all_hit || retry_max) begin
                    state_d = RESP;
                end else begin
                    miss_e  = need_e & ~hit_e;
                    miss_o  = need_o & ~hit_o;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!pend_e_nx && !pend_o_nx) state_d = LOOKUP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            op_q        <= '0;
            tag_q       <= '0;
            retry_q     <= '0;
            pend_e_q    <= 1'b0;
            pend_o_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        sext_q      <= req_sext;
                        op_q        <= req_op;
                        tag_q       <= req_tag;
                        retry_q     <= '0;
                        pend_e_q    <= 1'b0;
                        pend_o_q    <= 1'b0;
                        resp_data_q <= '0;
                        resp_err_q  <= req_illegal;
                    end
                end
                CHECK: begin
                    if (all_hit) begin
                        resp_data_q <= (op_q == OP_LD) ? mrg_data : 32'd0;
                    end else if (retry_max) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        pend_e_q <= need_e & ~hit_e;
                        pend_o_q <= need_o & ~hit_o;
                        retry_q  <= retry_q + RW'(1);
                    end
                end
                WAIT: begin
                    pend_e_q <= pend_e_nx;
                    pend_o_q <= pend_o_nx;
                end
                RESP: begin
                    if (resp_ready) retry_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_d_split_ctrl.sv
// tb/tb_d_split_ctrl.sv - directed self-checking bench for d_split_ctrl
module tb_d_split_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_sext = 1'b0;
    logic [2:0]  req_op = '0;
    logic [9:0]  req_tag = '0;
    logic        lk_e_valid, lk_o_valid;
    logic [31:0] lk_e_addr, lk_o_addr;
    logic        hit_e = 1'b0, hit_o = 1'b0;
    logic        miss_e, miss_o;
    logic        wake_e = 1'b0, wake_o = 1'b0;
    logic        use_e_as_0, need_p1, mrg_sext;
    logic [1:0]  mrg_size;
    logic [31:0] mrg_data = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_data;
    logic [9:0]  resp_tag;

    int n_checks = 0;
    int n_err    = 0;
    int cnt_lk_e = 0, cnt_lk_o = 0, cnt_miss_e = 0, cnt_miss_o = 0, cnt_resp = 0;

    d_split_ctrl #(.OOO_TAG_SIZE(10), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_op(req_op), .req_tag(req_tag),
        .lk_e_valid(lk_e_valid), .lk_e_addr(lk_e_addr),
        .lk_o_valid(lk_o_valid), .lk_o_addr(lk_o_addr),
        .hit_e(hit_e), .hit_o(hit_o), .miss_e(miss_e), .miss_o(miss_o),
        .wake_e(wake_e), .wake_o(wake_o),
        .use_e_as_0(use_e_as_0), .need_p1(need_p1), .mrg_size(mrg_size),
        .mrg_sext(mrg_sext), .mrg_data(mrg_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lk_e_valid) cnt_lk_e <= cnt_lk_e + 1;
        if (lk_o_valid) cnt_lk_o <= cnt_lk_o + 1;
        if (miss_e) cnt_miss_e <= cnt_miss_e + 1;
        if (miss_o) cnt_miss_o <= cnt_miss_o + 1;
        if (resp_valid && resp_ready) cnt_resp <= cnt_resp + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] s, input logic sx,
                        input logic [2:0] op, input logic [9:0] t);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        req_sext  = sx;
        req_op    = op;
        req_tag   = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int n);
        n = 0;
        while (!resp_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    int n, s_lk_e, s_lk_o, s_me, s_mo, s_resp;
    logic pend_flag;

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_lk_e_addr", lk_e_addr, 0);
        check("rst_use_e_as_0", use_e_as_0, 0);

        // LD word 0x100, even-bank hit only
        hit_e = 1'b1; hit_o = 1'b0; mrg_data = 32'hDEAD_BEEF;
        send(32'h100, 2'd3, 1'b0, 3'd1, 10'h2A5);
        check("t1_lk_e_valid", lk_e_valid, 1);
        check("t1_lk_o_valid", lk_o_valid, 0);
        check("t1_lk_e_addr", lk_e_addr, 32'h100);
        check("t1_use_e", use_e_as_0, 1);
        check("t1_need_p1", need_p1, 0);
        wait_resp(20, n);
        check("t1_latency", n, 2);
        check("t1_data", resp_data, 32'hDEAD_BEEF);
        check("t1_err", resp_err, 0);
        check("t1_tag", resp_tag, 10'h2A5);
        take_resp();
        check("t1_ready_after", req_ready, 1);

        // LD word 0x11E crossing lines, both hit
        hit_e = 1'b1; hit_o = 1'b1; mrg_data = 32'h1234_5678;
        s_resp = cnt_resp;
        send(32'h11E, 2'd3, 1'b0, 3'd1, 10'h011);
        check("t2_need_p1", need_p1, 1);
        check("t2_use_e", use_e_as_0, 0);
        check("t2_lk_o_addr", lk_o_addr, 32'h110);
        check("t2_lk_e_addr", lk_e_addr, 32'h120);
        check("t2_strobes", {lk_e_valid, lk_o_valid}, 2'b11);
        wait_resp(20, n);
        check("t2_data", resp_data, 32'h1234_5678);
        take_resp();
        repeat (3) tick();
        check("t2_resp_count", cnt_resp - s_resp, 1);

        // LD half 0x0F: odd bank misses, wait for wake, replay
        hit_e = 1'b1; hit_o = 1'b0; mrg_data = 32'hFFFF_8001;
        s_mo = cnt_miss_o; s_me = cnt_miss_e;
        send(32'h0F, 2'd1, 1'b1, 3'd1, 10'h077);
        check("t3_lk_e_addr", lk_e_addr, 32'h0);
        check("t3_lk_o_addr", lk_o_addr, 32'h10);
        check("t3_mrg", {need_p1, use_e_as_0, mrg_sext, mrg_size}, 5'b11101);
        tick();
        check("t3_miss_o", miss_o, 1);
        check("t3_miss_e", miss_e, 0);
        tick();
        hit_o = 1'b1;
        s_lk_o = cnt_lk_o;
        repeat (4) tick();
        check("t3_wait_no_lookup", cnt_lk_o - s_lk_o, 0);
        wake_e = 1'b1;
        tick();
        wake_e = 1'b0;
        check("t3_wake_e_ignored", {lk_e_valid, lk_o_valid, resp_valid}, 3'b000);
        wake_o = 1'b1;
        tick();
        wake_o = 1'b0;
        check("t3_replay_strobes", {lk_e_valid, lk_o_valid}, 2'b11);
        wait_resp(20, n);
        check("t3_latency", n, 2);
        check("t3_data", resp_data, 32'hFFFF_8001);
        check("t3_err", resp_err, 0);
        check("t3_miss_o_count", cnt_miss_o - s_mo, 1);
        check("t3_miss_e_count", cnt_miss_e - s_me, 0);
        take_resp();

        // Persistent even-bank miss exhausts retries
        hit_e = 1'b0; hit_o = 1'b0; mrg_data = 32'hAAAA_5555;
        s_me = cnt_miss_e; s_lk_e = cnt_lk_e;
        send(32'h200, 2'd3, 1'b0, 3'd1, 10'h3FF);
        pend_flag = 1'b0;
        n = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
            wake_e = pend_flag;
            pend_flag = miss_e;
        end
        wake_e = 1'b0;
        check("t4_resp_seen", resp_valid, 1);
        check("t4_miss_count", cnt_miss_e - s_me, 3);
        check("t4_lookup_count", cnt_lk_e - s_lk_e, 4);
        check("t4_err", resp_err, 1);
        check("t4_data", resp_data, 0);
        check("t4_tag", resp_tag, 10'h3FF);
        take_resp();

        // Word at 0xFFFF_FFFE wraps line1 to 0
        hit_e = 1'b1; hit_o = 1'b1; mrg_data = 32'h0BAD_F00D;
        send(32'hFFFF_FFFE, 2'd3, 1'b0, 3'd1, 10'h100);
        check("t5_lk_e_addr", lk_e_addr, 32'h0);
        check("t5_lk_o_addr", lk_o_addr, 32'hFFFF_FFF0);
        check("t5_need_p1", need_p1, 1);
        wait_resp(20, n);
        check("t5_data", resp_data, 32'h0BAD_F00D);
        take_resp();

        // Store that hits returns zero data
        send(32'h40, 2'd0, 1'b0, 3'd2, 10'h005);
        wait_resp(20, n);
        check("st_data", resp_data, 0);
        check("st_err", resp_err, 0);
        take_resp();

        // Illegal size and illegal op: immediate error, no lookups
        s_lk_e = cnt_lk_e; s_lk_o = cnt_lk_o;
        send(32'h80, 2'd2, 1'b0, 3'd1, 10'h0AB);
        check("ill_size_valid", resp_valid, 1);
        check("ill_size_err", resp_err, 1);
        check("ill_size_data", resp_data, 0);
        take_resp();
        send(32'h80, 2'd3, 1'b0, 3'd3, 10'h0AC);
        check("ill_op_resp", {resp_valid, resp_err}, 2'b11);
        check("ill_op_tag", resp_tag, 10'h0AC);
        take_resp();
        check("ill_no_lookup", (cnt_lk_e - s_lk_e) + (cnt_lk_o - s_lk_o), 0);

        // Back-pressure then asynchronous reset mid-RESP
        hit_e = 1'b1; mrg_data = 32'hCAFE_0001;
        send(32'h300, 2'd3, 1'b0, 3'd1, 10'h155);
        wait_resp(20, n);
        repeat (5) tick();
        check("bp_valid_held", resp_valid, 1);
        check("bp_data_held", resp_data, 32'hCAFE_0001);
        s_resp = cnt_resp;
        #2 rst = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_data_err_tag", {resp_err, resp_tag, resp_data}, 0);
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;
        repeat (4) tick();
        resp_ready = 1'b0;
        check("arst_no_resp", cnt_resp - s_resp, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
